// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill controller: FSM state encodings,
// the default refill timeout and word-alignment helpers.
package cache_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_FILL = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int TIMER_W         = 8;

    localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ADDR_MASK;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Blocking-load cache front end: serves hits directly and refills one word
// from backing memory on a miss, abandoning the refill after TIMEOUT cycles.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_rd,
    input  logic [31:0]      cpu_addr,
    output logic             stall,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_rdata_valid,
    input  logic             cache_hit,
    input  logic [31:0]      cache_rdata,
    output logic             fill_we,
    output logic [31:0]      fill_addr,
    output logic [31:0]      fill_data,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rsp_data,
    output logic             err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        rsp_q, rsp_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               hit_inc;
    logic               miss_inc;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        addr_d   = addr_q;
        rsp_d    = rsp_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_rd) begin
                    if (cache_hit) begin
                        rdata_d  = cache_rdata;
                        rvalid_d = 1'b1;
                        hit_inc  = 1'b1;
                    end else begin
                        addr_d   = word_align(cpu_addr);
                        miss_inc = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                // A response in the final wait cycle still wins over the timeout.
                if (mem_rsp_valid) begin
                    rsp_d   = mem_rsp_data;
                    state_d = ST_FILL;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_FILL: begin
                rdata_d  = rsp_q;
                rvalid_d = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_ERR: begin
                rdata_d  = '0;
                rvalid_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            addr_q   <= '0;
            rsp_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            addr_q   <= addr_d;
            rsp_q    <= rsp_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {miss_inc, hit_inc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign hit_cnt  = cnt_val[0];
    assign miss_cnt = cnt_val[1];

    // Stall is raised in the miss cycle itself so the CPU holds its request.
    assign stall = ((state_q == ST_IDLE) && cpu_rd && !cache_hit) ||
                   (state_q == ST_REQ) || (state_q == ST_WAIT);

    assign mem_req_valid   = (state_q == ST_REQ);
    assign mem_req_addr    = addr_q;
    assign fill_we         = (state_q == ST_FILL);
    assign fill_addr       = addr_q;
    assign fill_data       = rsp_q;
    assign err             = (state_q == ST_ERR);
    assign cpu_rdata       = rdata_q;
    assign cpu_rdata_valid = rvalid_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: a transaction-level model sets the
// expected outputs for every cycle and a compare process checks them.
module tb_cache_refill_ctrl;

    localparam int TO      = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_rd;
    logic [31:0]   cpu_addr;
    logic          stall;
    logic [31:0]   cpu_rdata;
    logic          cpu_rdata_valid;
    logic          cache_hit;
    logic [31:0]   cache_rdata;
    logic          fill_we;
    logic [31:0]   fill_addr;
    logic [31:0]   fill_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [31:0]   mem_req_addr;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_data;
    logic          err;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    always #5 clk = ~clk;

    cache_refill_ctrl #(
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_rd          (cpu_rd),
        .cpu_addr        (cpu_addr),
        .stall           (stall),
        .cpu_rdata       (cpu_rdata),
        .cpu_rdata_valid (cpu_rdata_valid),
        .cache_hit       (cache_hit),
        .cache_rdata     (cache_rdata),
        .fill_we         (fill_we),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .err             (err),
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state: architectural view of what the CPU should observe.
    int          m_hits = 0;
    int          m_misses = 0;
    logic [31:0] m_rdata = '0;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_rdata = '0;

    // Expected outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic        e_stall, e_valid, e_fill_we, e_mreq, e_err;
    logic [31:0] e_rdata, e_fill_addr, e_fill_data, e_mreq_addr;
    int          e_hit, e_miss;

    // Observations used by the directed literal checks.
    int          n_fill_seen = 0;
    int          n_err_seen = 0;
    int          n_mreq_seen = 0;
    int          n_addr_change = 0;
    int          last_err_cyc = 0;
    int          last_acc_cyc = 0;
    int          last_valid_cyc = 0;
    logic        prev_mreq = 1'b0;
    logic [31:0] prev_mreq_addr = '0;
    logic [31:0] seen_fill_addr = '0;
    logic [31:0] seen_fill_data = '0;
    logic [31:0] seen_mreq_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int x);
        return (x > CNT_MAX) ? CNT_MAX : x;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (chk_en) begin
                chk("stall", 32'(stall), 32'(e_stall));
                chk("rdata_valid", 32'(cpu_rdata_valid), 32'(e_valid));
                chk("rdata", cpu_rdata, e_rdata);
                chk("fill_we", 32'(fill_we), 32'(e_fill_we));
                if (e_fill_we) begin
                    chk("fill_addr", fill_addr, e_fill_addr);
                    chk("fill_data", fill_data, e_fill_data);
                end
                chk("mem_req_valid", 32'(mem_req_valid), 32'(e_mreq));
                if (e_mreq) chk("mem_req_addr", mem_req_addr, e_mreq_addr);
                chk("err", 32'(err), 32'(e_err));
                chk("hit_cnt", 32'(hit_cnt), 32'(e_hit));
                chk("miss_cnt", 32'(miss_cnt), 32'(e_miss));
            end
            if (!rst) begin
                if (fill_we) begin
                    n_fill_seen++;
                    seen_fill_addr = fill_addr;
                    seen_fill_data = fill_data;
                end
                if (err) begin
                    n_err_seen++;
                    last_err_cyc = cyc;
                end
                if (mem_req_valid) begin
                    n_mreq_seen++;
                    seen_mreq_addr = mem_req_addr;
                    if (prev_mreq && (mem_req_addr != prev_mreq_addr)) n_addr_change++;
                    if (mem_req_ready) last_acc_cyc = cyc;
                end
                if (cpu_rdata_valid) last_valid_cyc = cyc;
                prev_mreq      = mem_req_valid;
                prev_mreq_addr = mem_req_addr;
            end
            cyc++;
        end
    end

    task automatic begin_cycle();
        e_valid = pend_valid;
        if (pend_valid) m_rdata = pend_rdata;
        pend_valid  = 1'b0;
        e_rdata     = m_rdata;
        e_hit       = m_hits;
        e_miss      = m_misses;
        e_stall     = 1'b0;
        e_fill_we   = 1'b0;
        e_mreq      = 1'b0;
        e_err       = 1'b0;
        e_fill_addr = '0;
        e_fill_data = '0;
        e_mreq_addr = '0;
        chk_en      = 1'b1;
        rst         = 1'b0;
        cpu_rd        = 1'b0;
        cpu_addr      = $urandom;
        cache_hit     = 1'($urandom_range(0, 1));
        cache_rdata   = $urandom;
        mem_req_ready = 1'($urandom_range(0, 1));
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_data  = $urandom;
    endtask

    task automatic end_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        begin_cycle();
        chk_en = 1'b0;
        rst    = 1'b1;
        end_cycle();
        m_hits     = 0;
        m_misses   = 0;
        m_rdata    = '0;
        pend_valid = 1'b0;
    endtask

    task automatic do_idle();
        begin_cycle();
        end_cycle();
    endtask

    task automatic do_hit(input logic [31:0] d);
        begin_cycle();
        cpu_rd      = 1'b1;
        cache_hit   = 1'b1;
        cache_rdata = d;
        end_cycle();
        m_hits     = sat(m_hits + 1);
        pend_valid = 1'b1;
        pend_rdata = d;
    endtask

    // One miss: request phase of rdy_dly stalled cycles, response after
    // rsp_dly wait cycles (>= TO means timeout), optional reset in wait cycle rst_w.
    task automatic do_miss(input logic [31:0] addr, input int rdy_dly, input int rsp_dly,
                           input logic [31:0] d, input int rst_w);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        begin_cycle();
        cpu_rd    = 1'b1;
        cache_hit = 1'b0;
        cpu_addr  = addr;
        e_stall   = 1'b1;
        end_cycle();
        m_misses = sat(m_misses + 1);
        for (int k = 0; k <= rdy_dly; k++) begin
            begin_cycle();
            cpu_rd        = 1'($urandom_range(0, 1));
            mem_req_ready = (k == rdy_dly);
            e_stall       = 1'b1;
            e_mreq        = 1'b1;
            e_mreq_addr   = a;
            end_cycle();
        end
        for (int w = 0; w < TO; w++) begin
            if (w == rst_w) begin
                do_reset();
                return;
            end
            begin_cycle();
            cpu_rd        = 1'($urandom_range(0, 1));
            mem_rsp_valid = (w == rsp_dly);
            mem_rsp_data  = d;
            e_stall       = 1'b1;
            end_cycle();
            if (w == rsp_dly) begin
                begin_cycle();
                cpu_rd      = 1'($urandom_range(0, 1));
                e_fill_we   = 1'b1;
                e_fill_addr = a;
                e_fill_data = d;
                end_cycle();
                pend_valid = 1'b1;
                pend_rdata = d;
                return;
            end
        end
        begin_cycle();
        cpu_rd = 1'($urandom_range(0, 1));
        e_err  = 1'b1;
        end_cycle();
        pend_valid = 1'b1;
        pend_rdata = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m0, f0, e0, q0;
        rst           = 1'b1;
        cpu_rd        = 1'b0;
        cpu_addr      = '0;
        cache_hit     = 1'b0;
        cache_rdata   = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        @(negedge clk);
        do_reset();
        do_reset();

        begin_cycle();
        #4;
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        end_cycle();

        do_hit(32'hDEAD_BEEF);
        begin_cycle();
        #4;
        chk("hit_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("hit_valid", 32'(cpu_rdata_valid), 32'd1);
        chk("hit_stall", 32'(stall), 32'd0);
        chk("hit_cnt_one", 32'(hit_cnt), 32'd1);
        end_cycle();

        f0 = n_fill_seen;
        do_miss(32'h0000_0207, 0, 2, 32'h1234_5678, -1);
        begin_cycle();
        #4;
        chk("miss_mreq_addr", seen_mreq_addr, 32'h0000_0204);
        chk("miss_fill_addr", seen_fill_addr, 32'h0000_0204);
        chk("miss_fill_data", seen_fill_data, 32'h1234_5678);
        chk("miss_rdata", cpu_rdata, 32'h1234_5678);
        chk("miss_cnt_one", 32'(miss_cnt), 32'd1);
        chk("miss_fill_pulses", n_fill_seen - f0, 32'd1);
        end_cycle();

        m0 = cyc;
        do_miss(32'h0000_0810, 0, 0, 32'h0BAD_F00D, -1);
        begin_cycle();
        #4;
        chk("miss_latency", last_valid_cyc - m0, 32'd4);
        end_cycle();

        q0 = n_mreq_seen;
        do_miss(32'h0000_ABCD, 5, 0, 32'hCAFE_F00D, -1);
        do_idle();
        chk("bp_req_cycles", n_mreq_seen - q0, 32'd6);
        chk("bp_addr", seen_mreq_addr, 32'h0000_ABCC);
        chk("bp_addr_changes", n_addr_change, 32'd0);

        e0 = n_err_seen;
        f0 = n_fill_seen;
        do_miss(32'h0000_1000, 1, 99, 32'hFFFF_FFFF, -1);
        begin_cycle();
        #4;
        chk("to_err_pulses", n_err_seen - e0, 32'd1);
        chk("to_fill_pulses", n_fill_seen - f0, 32'd0);
        chk("to_latency", last_err_cyc - last_acc_cyc, 32'd5);
        chk("to_rdata", cpu_rdata, 32'd0);
        chk("to_valid", 32'(cpu_rdata_valid), 32'd1);
        end_cycle();

        f0 = n_fill_seen;
        do_miss(32'h0000_0300, 0, 99, 32'h55AA_55AA, 1);
        for (int i = 0; i < 3; i++) begin
            begin_cycle();
            mem_rsp_valid = 1'b1;
            end_cycle();
        end
        begin_cycle();
        mem_rsp_valid = 1'b1;
        #4;
        chk("rstw_fill_pulses", n_fill_seen - f0, 32'd0);
        chk("rstw_stall", 32'(stall), 32'd0);
        chk("rstw_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rstw_miss_cnt", 32'(miss_cnt), 32'd0);
        end_cycle();

        for (int i = 0; i < 17; i++) do_hit($urandom);
        begin_cycle();
        #4;
        chk("sat_hit_cnt", 32'(hit_cnt), 32'h0000_000F);
        end_cycle();

        for (int t = 0; t < 400; t++) begin
            int r;
            int rw;
            r = $urandom_range(0, 99);
            if (r < 40) begin
                do_hit($urandom);
            end else if (r < 80) begin
                rw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
                do_miss($urandom, $urandom_range(0, 3), $urandom_range(0, 5), $urandom, rw);
            end else if (r < 97) begin
                do_idle();
            end else begin
                do_reset();
            end
        end
        do_idle();
        do_idle();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of WAIT cycles before a refill is abandoned (range 1..255).
REQ-002 Parameter CNT_W, default 16, is the width of the hit and miss statistics counters.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port rst: input, 1 bit, synchronous active-high reset.
REQ-006 Port cpu_rd: input, 1 bit, CPU load request, sampled only in IDLE.
REQ-007 Port cpu_addr: input, 32 bits, CPU load byte address.
REQ-008 Port stall: output, 1 bit, CPU hold.
REQ-009 Port cpu_rdata: output, 32 bits, load result.
REQ-010 Port cpu_rdata_valid: output, 1 bit, one-cycle pulse qualifying cpu_rdata.
REQ-011 Port cache_hit: input, 1 bit, cache lookup hit for cpu_addr.
REQ-012 Port cache_rdata: input, 32 bits, cache read word.
REQ-013 Port fill_we: output, 1 bit, cache write strobe for refill.
REQ-014 Port fill_addr: output, 32 bits, refill word address with bits [1:0] = 0.
REQ-015 Port fill_data: output, 32 bits, refill word.
REQ-016 Port mem_req_valid: output, 1 bit, backing-memory read request.
REQ-017 Port mem_req_ready: input, 1 bit, memory accepts the request.
REQ-018 Port mem_req_addr: output, 32 bits, word-aligned request address.
REQ-019 Port mem_rsp_valid: input, 1 bit, memory response strobe.
REQ-020 Port mem_rsp_data: input, 32 bits, memory response word.
REQ-021 Port err: output, 1 bit, one-cycle pulse when a refill times out.
REQ-022 Ports hit_cnt and miss_cnt: outputs, CNT_W bits each, saturating statistics counters.

Function
REQ-023 The FSM shall have states IDLE, REQ, WAIT, FILL and ERR, encoded in 3 bits.
REQ-024 IDLE, cpu_rd=1 and cache_hit=1: the block shall register cache_rdata to cpu_rdata, pulse cpu_rdata_valid on the next cycle, increment hit_cnt and remain in IDLE.
REQ-025 IDLE, cpu_rd=1 and cache_hit=0: the block shall latch {cpu_addr[31:2],2'b00}, increment miss_cnt and go to REQ.
REQ-026 stall shall equal (state==IDLE && cpu_rd && !cache_hit) || state==REQ || state==WAIT, combinationally.
REQ-027 REQ: mem_req_valid=1 and mem_req_addr shall hold the latched address stable until mem_req_ready=1 in the same cycle, then the block shall go to WAIT with the timer cleared.
REQ-028 WAIT: the 8-bit timer shall increment each cycle; mem_rsp_valid=1 shall capture mem_rsp_data and go to FILL, taking priority if it coincides with timer==TIMEOUT-1.
REQ-029 WAIT: timer reaching TIMEOUT-1 without mem_rsp_valid shall go to ERR.
REQ-030 FILL (one cycle): fill_we=1, fill_addr=latched address, fill_data=captured word; cpu_rdata and cpu_rdata_valid shall be updated on the same edge that leaves FILL; next state IDLE.
REQ-031 ERR (one cycle): err=1; cpu_rdata=0 with cpu_rdata_valid pulsed on exit; no fill_we; next state IDLE.
REQ-032 mem_rsp_valid outside WAIT and cpu_rd outside IDLE shall be ignored.
REQ-033 Counters shall saturate at all-ones and never wrap.
REQ-034 Miss-to-data latency with zero-wait memory (ready and rsp next cycle) shall be 4 cycles from the miss cycle to cpu_rdata_valid.

Reset
REQ-035 rst=1 shall force state IDLE, the timer, hit_cnt, miss_cnt, cpu_rdata and the latched address to 0, and cpu_rdata_valid, fill_we, mem_req_valid and err to 0, overriding any in-flight refill.
REQ-036 A response arriving after a mid-refill reset shall be discarded.

Structure
REQ-037 State encodings, TIMEOUT default and address alignment constants shall live in shared package cache_pkg.
REQ-038 The saturating counter shall be a sub-module sat_counter instantiated twice; everything else is flat.

Verification
REQ-039 Hit: cpu_rd=1, cache_hit=1, cache_rdata=0xDEADBEEF -> next cycle cpu_rdata=0xDEADBEEF, cpu_rdata_valid=1, stall=0, hit_cnt=1.
REQ-040 Miss: cpu_addr=0x0000_0207, cache_hit=0, memory returns 0x12345678 after 3 cycles -> mem_req_addr=0x204, fill_we pulse with fill_addr=0x204 and fill_data=0x12345678, cpu_rdata=0x12345678, miss_cnt=1.
REQ-041 Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and address held stable, stall=1 throughout.
REQ-042 Timeout: TIMEOUT=4, no response -> err pulse 4 cycles after entering WAIT, cpu_rdata=0, no fill_we, state IDLE.
REQ-043 Reset mid-WAIT, then mem_rsp_valid=1 -> no fill_we, stall=0, counters 0.
REQ-044 Saturation: CNT_W=4, 17 hits -> hit_cnt=0xF.
